// File: rtl/sequential_divider.sv
// Iterative restoring divider: unsigned OperX / OperY, one quotient bit per clock.
// Start/Busy/Done handshake; a zero divisor finishes early with DivByZero set.
module sequential_divider #(
  parameter int OPER1_LENGTH = 3,
  parameter int OPER2_LENGTH = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Start,
  input  logic [OPER1_LENGTH-1:0] OperX,
  input  logic [OPER2_LENGTH-1:0] OperY,
  output logic [OPER1_LENGTH-1:0] Quotient,
  output logic [OPER2_LENGTH-1:0] Remainder,
  output logic                    Busy,
  output logic                    Done,
  output logic                    DivByZero
);

  // state  | meaning
  // IDLE   | waiting for Start; operands latched on the accepting edge
  // CALC   | one restoring step per edge, OPER1_LENGTH steps
  // FINISH | publish results, pulse Done, return to IDLE
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  localparam int CW = $clog2(OPER1_LENGTH + 1);

  state_t                  state_q, state_d;
  logic [OPER1_LENGTH-1:0] dvd_q, dvd_d;
  logic [OPER2_LENGTH-1:0] dvs_q, dvs_d;
  logic [OPER2_LENGTH-1:0] rem_q, rem_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    zero_q, zero_d;
  logic [OPER1_LENGTH-1:0] quot_q, quot_d;
  logic [OPER2_LENGTH-1:0] remo_q, remo_d;
  logic                    done_q, done_d;
  logic                    dbz_q, dbz_d;
  logic [OPER2_LENGTH:0]   r_shift, trial;

  // A restored remainder is always below the divisor, so the top bit of the
  // (OPER2_LENGTH+1)-bit partial remainder is only ever non-zero in r_shift.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    r_shift = {rem_q, dvd_q[OPER1_LENGTH-1]};
    trial   = r_shift - {1'b0, dvs_q};
    case (state_q)
      IDLE: begin
        if (Start) begin
          dvd_d   = OperX;
          dvs_d   = OperY;
          rem_d   = '0;
          cnt_d   = CW'(OPER1_LENGTH);
          zero_d  = (OperY == '0);
          state_d = (OperY == '0) ? FINISH : CALC;
        end
      end
      CALC: begin
        dvd_d = {dvd_q[OPER1_LENGTH-2:0], ~trial[OPER2_LENGTH]};
        rem_d = trial[OPER2_LENGTH] ? r_shift[OPER2_LENGTH-1:0] : trial[OPER2_LENGTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_q) begin
          quot_d = '1;
          remo_d = '0;
          dbz_d  = 1'b1;
        end else begin
          quot_d = dvd_q;
          remo_d = rem_q;
          dbz_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = remo_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule
